uart_receiver: RTL and testbench

//  Receive side of the sys-array serial link; pairs with uart_transmitter.

---
 rtl/uart_receiver.sv | 139 +++++++++++++
 tb/tb_uart_receiver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// Serial link receiver: synchronises serial_in, deserialises MSB-first frames into a
// small byte FIFO, and exposes the FIFO head on a valid/ready port with cts flow control.
module uart_receiver #(
    parameter int SYMBOL_EDGE_TIME = 868,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic       cts,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       rx_running,
    output logic       frame_error,
    output logic       overrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0]   SYM_M1   = 32'(SYMBOL_EDGE_TIME - 1);
    localparam logic [31:0]   HALF_M1  = 32'(SYMBOL_EDGE_TIME / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CTS_MAX  = CW'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {IDLE, START, DATA, FINISH, WAIT_HIGH} state_e;

    logic [1:0]    sync_q;
    logic          rx_sync;
    state_e        state_q, state_d;
    logic [31:0]   ctr_q, ctr_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_error_q, frame_error_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_req, push_ok, pop;

    assign rx_sync        = sync_q[1];
    assign data_out_valid = (count_q != '0);
    assign data_out       = mem_q[rptr_q];
    assign cts            = (count_q <= CTS_MAX);
    assign rx_running     = (state_q != IDLE);
    assign frame_error    = frame_error_q;
    assign overrun        = overrun_q;
    assign pop            = data_out_valid & data_out_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        ctr_d         = ctr_q + 32'd1;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        frame_error_d = 1'b0;
        push_req      = 1'b0;
        case (state_q)
            IDLE: begin
                ctr_d = '0;
                if (!rx_sync) state_d = START;
            end
            START: if (ctr_q == HALF_M1) begin
                ctr_d   = '0;
                state_d = rx_sync ? IDLE : DATA;
                bit_idx_d = 3'd7;
            end
            DATA: if (ctr_q == SYM_M1) begin
                ctr_d = '0;
                shift_d[bit_idx_q] = rx_sync;
                if (bit_idx_q == 3'd0) state_d = FINISH;
                else                   bit_idx_d = bit_idx_q - 3'd1;
            end
            FINISH: if (ctr_q == SYM_M1) begin
                ctr_d   = '0;
                state_d = WAIT_HIGH;
                if (rx_sync) frame_error_d = 1'b1;
                else         push_req      = 1'b1;
            end
            WAIT_HIGH: begin
                // Finish symbol is low; wait for the line to return high before re-arming.
                ctr_d = '0;
                if (rx_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_ok   = push_req && ((count_q != FULL_CNT) || pop);
        overrun_d = push_req && !push_ok;
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = shift_q;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            sync_q        <= 2'b11;
            state_q       <= IDLE;
            ctr_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            // NOTE: storage is reset because data_out reads it directly and must be 0 in reset.
            mem_q         <= '{default: '0};
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
        end else begin
            sync_q        <= {sync_q[0], serial_in};
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            mem_q         <= mem_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with 8-clock symbols and a 4-entry FIFO.
module tb_uart_receiver;

    localparam int SET   = 8;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic       cts, data_out_valid, rx_running, frame_error, overrun;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int rise_cyc = -1;
    int start_edge;
    logic       valid_prev = 1'b0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_b [4];

    uart_receiver #(.SYMBOL_EDGE_TIME(SET), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .serial_in(serial_in), .cts(cts),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .rx_running(rx_running),
        .frame_error(frame_error), .overrun(overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: collects popped bytes, counts flag cycles, timestamps first valid rise.
    always @(negedge clock) begin
        if (data_out_valid && data_out_ready) rx_q.push_back(data_out);
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if (overrun)     ov_cnt <= ov_cnt + 1;
        if (data_out_valid && !valid_prev && rise_cyc < 0) rise_cyc <= cyc;
        valid_prev <= data_out_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic drive_sym(input logic b);
        serial_in = b;
        repeat (SET) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic fin);
        drive_sym(1'b0);
        for (int i = 7; i >= 0; i--) drive_sym(b[i]);
        drive_sym(fin);
        serial_in = 1'b1;
    endtask

    initial begin
        // Reset values while reset is held
        repeat (2) @(posedge clock);
        #1;
        check("rst valid", data_out_valid, 0);
        check("rst running", rx_running, 0);
        check("rst frame_error", frame_error, 0);
        check("rst overrun", overrun, 0);
        check("rst cts", cts, 1);
        check("rst data_out", data_out, 8'h00);
        reset = 1'b0;
        idle(3);

        // T1: single frame latency
        data_out_ready = 1'b1;
        rx_q.delete();
        start_edge = cyc + 1;
        send_frame(8'hA5, 1'b0);
        idle(4);
        check("T1 latency", rise_cyc - start_edge, 78);
        check("T1 count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("T1 data", rx_q[0], 8'hA5);
        check("T1 frame_error", fe_cnt, 0);
        check("T1 overrun", ov_cnt, 0);

        // T2: back-to-back frames with one idle clock
        rx_q.delete();
        exp_b = '{8'h00, 8'hFF, 8'h81, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            send_frame(exp_b[i], 1'b0);
            idle(1);
        end
        idle(5);
        check("T2 count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rx_q.size()) check("T2 data", rx_q[i], exp_b[i]);
        check("T2 frame_error", fe_cnt, 0);
        check("T2 overrun", ov_cnt, 0);

        // T3: fill FIFO, overrun on fifth frame, then drain
        data_out_ready = 1'b0;
        rx_q.delete();
        send_frame(8'h11, 1'b0); check("T3 cts after 1", cts, 1); idle(1);
        send_frame(8'h22, 1'b0); check("T3 cts after 2", cts, 1); idle(1);
        send_frame(8'h33, 1'b0); check("T3 cts after 3", cts, 0); idle(1);
        send_frame(8'h44, 1'b0); check("T3 ov after 4", ov_cnt, 0); idle(1);
        send_frame(8'h55, 1'b0);
        check("T3 overrun pulse", ov_cnt, 1);
        check("T3 head stable", data_out, 8'h11);
        check("T3 valid held", data_out_valid, 1);
        idle(3);
        data_out_ready = 1'b1;
        idle(10);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        check("T3 drained count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rx_q.size()) check("T3 data", rx_q[i], exp_b[i]);
        check("T3 cts after drain", cts, 1);
        check("T3 valid after drain", data_out_valid, 0);
        check("T3 frame_error", fe_cnt, 0);

        // T4: bad finish symbol, then a good frame
        rx_q.delete();
        send_frame(8'h5A, 1'b1);
        idle(4);
        check("T4 frame_error pulse", fe_cnt, 1);
        check("T4 no push", rx_q.size(), 0);
        check("T4 overrun", ov_cnt, 1);
        send_frame(8'h12, 1'b0);
        idle(4);
        check("T4 good count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("T4 good data", rx_q[0], 8'h12);

        // T5: short low glitch on idle line
        rx_q.delete();
        serial_in = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("T5 start entered", rx_running, 1);
        idle(20);
        check("T5 back to idle", rx_running, 0);
        check("T5 no push", rx_q.size(), 0);
        check("T5 frame_error", fe_cnt, 1);
        check("T5 overrun", ov_cnt, 1);

        // T6: reset in the middle of a frame with a byte already queued
        data_out_ready = 1'b0;
        send_frame(8'h99, 1'b0);
        idle(2);
        check("T6 queued valid", data_out_valid, 1);
        drive_sym(1'b0);
        drive_sym(1'b0);
        drive_sym(1'b1);
        drive_sym(1'b1);
        reset = 1'b1;
        #2;
        check("T6 rst running", rx_running, 0);
        check("T6 rst valid", data_out_valid, 0);
        check("T6 rst data_out", data_out, 8'h00);
        check("T6 rst cts", cts, 1);
        serial_in = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("T6 rst frame_error", frame_error, 0);
        check("T6 rst overrun", overrun, 0);
        reset = 1'b0;
        idle(4);
        rx_q.delete();
        data_out_ready = 1'b1;
        send_frame(8'hC3, 1'b0);
        idle(4);
        check("T6 count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("T6 data", rx_q[0], 8'hC3);
        check("T6 frame_error", fe_cnt, 1);
        check("T6 overrun", ov_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
